// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: default sizes and FSM state encoding.
package spi_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SHIFT   = 2'd2,
    WAIT_CS = 2'd3
  } state_t;

endpackage

// File: rtl/spi_target_sync_if.sv
// Parallel-side bus of the SPI target: tx word handshake, rx word and status pulses.
interface spi_target_sync_if #(
  parameter int DATA_W = spi_pkg::DEF_DATA_W
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              underrun;
  logic              abort;
  logic              busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, underrun, abort, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, underrun, abort, busy
  );

endinterface

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer with a selectable reset value.
module spi_sync #(
  parameter int   SYNC_STAGES = spi_pkg::DEF_SYNC_STAGES,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RST_VAL}};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_target_sync.sv
// SPI mode-0 target oversampled by the system clock, with a one-entry tx buffer.
module spi_target_sync
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  spi_target_sync_if.slave bus
);

  localparam int                CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam int                WAIT_W   = $clog2(SYNC_STAGES + 1);
  localparam logic [WAIT_W-1:0] FLUSHED  = WAIT_W'(SYNC_STAGES);

  state_t              state;
  logic                sclk_s, cs_s, mosi_s, sclk_q;
  logic                rise, fall;
  logic [DATA_W-1:0]   tx_sr, tx_buf, next_word, rx_next;
  logic [DATA_W-2:0]   rx_sr;
  logic                tx_full, tx_write;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                reload_pend, under_pend;
  logic                oe_r, rx_valid_r, underrun_r, abort_r;
  logic [DATA_W-1:0]   rx_data_r;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs), .q(cs_s));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

  assign rise      = sclk_s & ~sclk_q;
  assign fall      = ~sclk_s & sclk_q;
  assign tx_write  = bus.tx_valid & ~tx_full;
  // An empty buffer loads zeros so the master reads a clean all-zero word
  assign next_word = tx_full ? tx_buf : '0;
  assign rx_next   = {rx_sr, mosi_s};

  assign miso         = tx_sr[DATA_W-1];
  assign miso_oe      = oe_r;
  assign bus.tx_ready = ~tx_full;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.underrun = underrun_r;
  assign bus.abort    = abort_r;
  assign bus.busy     = (state != IDLE);

  // Control FSM, tx buffer and shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_CS;
      wait_cnt    <= '0;
      sclk_q      <= 1'b0;
      tx_sr       <= '0;
      tx_full     <= 1'b0;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
      under_pend  <= 1'b0;
      oe_r        <= 1'b0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      underrun_r  <= 1'b0;
      abort_r     <= 1'b0;
    end else begin
      sclk_q     <= sclk_s;
      rx_valid_r <= 1'b0;
      underrun_r <= 1'b0;
      abort_r    <= 1'b0;
      if (tx_write) begin
        tx_buf  <= bus.tx_data;
        tx_full <= 1'b1;
      end
      case (state)
        // Let the cs synchronizer flush its reset value before trusting it,
        // so a frame already running at reset is never picked up halfway
        WAIT_CS: begin
          if (wait_cnt != FLUSHED) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else if (cs_s) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (!cs_s) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          tx_sr   <= next_word;
          oe_r    <= 1'b1;
          bit_cnt <= '0;
          state   <= SHIFT;
          if (tx_full) begin
            tx_full <= 1'b0;
          end else begin
            underrun_r <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            if (bit_cnt != '0) begin
              abort_r <= 1'b1;
            end
            state       <= IDLE;
            tx_sr       <= '0;
            oe_r        <= 1'b0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            under_pend  <= 1'b0;
          end else if (rise) begin
            rx_sr <= rx_next[DATA_W-2:0];
            // A boundary reload from an empty buffer only counts once the
            // master actually clocks the next frame
            if (under_pend) begin
              underrun_r <= 1'b1;
              under_pend <= 1'b0;
            end
            if (bit_cnt == LAST_BIT) begin
              bit_cnt     <= '0;
              rx_data_r   <= rx_next;
              rx_valid_r  <= 1'b1;
              reload_pend <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (fall) begin
            if (reload_pend) begin
              reload_pend <= 1'b0;
              tx_sr       <= next_word;
              if (tx_full) begin
                tx_full <= 1'b0;
              end else begin
                under_pend <= 1'b1;
              end
            end else begin
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: state <= WAIT_CS;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target_sync.sv
// Directed bench for spi_target_sync: bit-level SPI master, word-level model and checker.
module tb_spi_target_sync;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic cs = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe;

  spi_target_sync_if #(.DATA_W(W)) bus ();

  spi_target_sync #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Word-level model: words the master completed, last delivered word, pulse counts
  logic [W-1:0] exp_rx_q[$];
  logic [W-1:0] model_rx = '0;
  int rxv_cnt = 0, und_cnt = 0, abt_cnt = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    rxv_cnt = 0;
    und_cnt = 0;
    abt_cnt = 0;
  endtask

  // Offer a word and hold it until accepted, bounded
  task automatic tx_put(input logic [W-1:0] d);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (!ok && n < 400) begin
      ok = bus.tx_ready;
      clks(1);
      n++;
    end
    bus.tx_valid = 1'b0;
    check("tx_put_accepted", ok, 1'b1);
  endtask

  // Mode-0 master: drive mosi during low phase, sample miso just before the rise
  task automatic spi_bits(input logic [W-1:0] mo, input int first, input int nbits,
                          output logic [W-1:0] mi);
    mi = '0;
    for (int i = first; i > first - nbits; i--) begin
      mosi = mo[i];
      clks(4);
      mi[i] = miso;
      if (first == W - 1 && nbits == W && i == 0) exp_rx_q.push_back(mo);
      sclk = 1'b1;
      clks(4);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs = 1'b0;
    clks(4);
  endtask

  task automatic cs_end();
    clks(4);
    cs = 1'b1;
    clks(8);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"}, miso, 1'b0);
    check({tag, "_miso_oe"}, miso_oe, 1'b0);
    check({tag, "_tx_ready"}, bus.tx_ready, 1'b1);
    check({tag, "_rx_data"}, bus.rx_data, 8'h00);
    check({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
    check({tag, "_underrun"}, bus.underrun, 1'b0);
    check({tag, "_abort"}, bus.abort, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b1);
  endtask

  // Compare process: every cycle, pulses and rx_data against the word model
  initial begin
    logic r;
    forever begin
      @(posedge clk);
      r = rst;
      @(negedge clk);
      if (mon_en) begin
        if (r) begin
          model_rx = '0;
          exp_rx_q.delete();
          check("mon_rst_rx_valid", bus.rx_valid, 1'b0);
          check("mon_rst_abort", bus.abort, 1'b0);
          check("mon_rst_rx_data", bus.rx_data, 8'h00);
        end else begin
          check("mon_pulse_exclusive", bus.rx_valid & bus.abort, 1'b0);
          if (bus.rx_valid) begin
            rxv_cnt++;
            check("mon_rx_word_expected", exp_rx_q.size() > 0, 1'b1);
            if (exp_rx_q.size() > 0) model_rx = exp_rx_q.pop_front();
          end
          if (bus.underrun) und_cnt++;
          if (bus.abort) abt_cnt++;
          check("mon_rx_data", bus.rx_data, model_rx);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] m0, m1;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;

    // Reset state
    rst = 1'b1;
    clks(3);
    check_reset_values("reset");
    rst = 1'b0;
    mon_en = 1'b1;
    clks(6);
    check("idle_busy", bus.busy, 1'b0);

    // Single frame: A5 out, 5A in
    clear_counts();
    tx_put(8'hA5);
    check("s1_tx_ready_full", bus.tx_ready, 1'b0);
    fork
      begin
        cs_begin();
        spi_bits(8'h5A, W - 1, W, m0);
        cs_end();
      end
      begin
        clks(7);
        check("s1_tx_ready_after_load", bus.tx_ready, 1'b1);
        check("s1_miso_oe_selected", miso_oe, 1'b1);
        check("s1_busy", bus.busy, 1'b1);
      end
    join
    check("s1_miso_word", m0, 8'b1010_0101);
    check("s1_rx_data", bus.rx_data, 8'h5A);
    check("s1_rx_valid_count", rxv_cnt, 1);
    check("s1_underrun_count", und_cnt, 0);
    check("s1_miso_oe_idle", miso_oe, 1'b0);
    check("s1_busy_idle", bus.busy, 1'b0);

    // Back-to-back frames with the second word queued mid-frame
    clear_counts();
    tx_put(8'h3C);
    fork
      begin
        cs_begin();
        spi_bits(8'hC3, W - 1, W, m0);
        spi_bits(8'h0F, W - 1, W, m1);
        cs_end();
      end
      tx_put(8'hF0);
    join
    check("s2_miso_word0", m0, 8'h3C);
    check("s2_miso_word1", m1, 8'hF0);
    check("s2_rx_valid_count", rxv_cnt, 2);
    check("s2_rx_data", bus.rx_data, 8'h0F);
    check("s2_underrun_count", und_cnt, 0);

    // Underrun: nothing to send
    clear_counts();
    cs_begin();
    spi_bits(8'h0F, W - 1, W, m0);
    cs_end();
    check("s3_miso_word", m0, 8'h00);
    check("s3_underrun_count", und_cnt, 1);
    check("s3_rx_valid_count", rxv_cnt, 1);
    check("s3_rx_data", bus.rx_data, 8'h0F);

    // Abort after 5 bits, then a full frame
    clear_counts();
    tx_put(8'h96);
    cs_begin();
    spi_bits(8'hFF, W - 1, 5, m0);
    clks(2);
    cs = 1'b1;
    clks(8);
    check("s4_partial_miso", m0, 8'h90);
    check("s4_abort_count", abt_cnt, 1);
    check("s4_rx_valid_count", rxv_cnt, 0);
    check("s4_rx_data_held", bus.rx_data, 8'h0F);
    check("s4_miso_oe", miso_oe, 1'b0);
    check("s4_busy", bus.busy, 1'b0);
    tx_put(8'hC5);
    cs_begin();
    spi_bits(8'h3A, W - 1, W, m0);
    cs_end();
    check("s4_next_miso", m0, 8'hC5);
    check("s4_next_rx_data", bus.rx_data, 8'h3A);
    check("s4_next_rx_valid_count", rxv_cnt, 1);
    check("s4_abort_total", abt_cnt, 1);
    check("s4_underrun_count", und_cnt, 0);

    // Reset in the middle of a frame with cs held low
    clear_counts();
    tx_put(8'h77);
    cs_begin();
    spi_bits(8'hE7, W - 1, 3, m0);
    rst = 1'b1;
    clks(1);
    check_reset_values("s5_reset");
    clks(1);
    rst = 1'b0;
    spi_bits(8'hE7, 4, 5, m1);
    clks(4);
    check("s5_busy_wait_cs", bus.busy, 1'b1);
    check("s5_miso_oe_wait_cs", miso_oe, 1'b0);
    cs = 1'b1;
    clks(8);
    check("s5_busy_idle", bus.busy, 1'b0);
    check("s5_rx_valid_count", rxv_cnt, 0);
    check("s5_abort_count", abt_cnt, 0);
    check("s5_underrun_count", und_cnt, 0);
    check("s5_rx_data", bus.rx_data, 8'h00);
    tx_put(8'hA5);
    cs_begin();
    spi_bits(8'h5A, W - 1, W, m0);
    cs_end();
    check("s5_after_miso", m0, 8'hA5);
    check("s5_after_rx_data", bus.rx_data, 8'h5A);
    check("s5_after_rx_valid_count", rxv_cnt, 1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
